sobol_bsgen: RTL and testbench
==============================

SOBOL_BSGEN -- requirements
Module: sobol_bsgen

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: width of source operand and random input; stream length 2^BITWIDTH.
REQ-002 SHALL have port iClk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iStart  input  1  request to generate one stream; sampled only in IDLE.
REQ-005 SHALL have port iSource  input  BITWIDTH  unsigned binary operand; latched on accepted iStart.
REQ-006 SHALL have port iRand  input  BITWIDTH  low-discrepancy random number from the upstream Sobol generator.
REQ-007 SHALL have port oRngSel  output  1  advance enable to the upstream generator (its iSel).
REQ-008 SHALL have port oRngClr  output  1  synchronous clear to the upstream generator (its iClr).
REQ-009 SHALL have port oBit  output  1  stochastic bitstream bit, registered.
REQ-010 SHALL have port oValid  output  1  oBit qualifier, registered.
REQ-011 SHALL have port oBusy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port oDone  output  1  one-cycle pulse at stream end.
REQ-013 SHALL have port oOnes  output  BITWIDTH+1  count of 1s emitted in the last/current stream.

Function
REQ-014 SHALL implement FSM states IDLE, CLR, RUN, DONE.
REQ-015 IDLE: iStart=1 SHALL latch iSource into srcReg, clear oOnes to 0 and cycle counter to 0, go to CLR; iStart=0 stays IDLE.
REQ-016 CLR: oRngClr=1, oRngSel=0 for exactly one cycle; unconditional transition to RUN.
REQ-017 RUN: oRngSel=1, oRngClr=0 combinationally; each RUN cycle SHALL register oBit <= (srcReg > iRand) unsigned, oValid <= 1, oOnes += that bit.
REQ-018 RUN SHALL last exactly 2^BITWIDTH cycles, counted by a BITWIDTH-bit counter; counter = 2^BITWIDTH-1 transitions to DONE.
REQ-019 Latency: iRand sampled in RUN cycle k SHALL appear as oBit/oValid in cycle k+1; first oValid one cycle after RUN entry, last oValid in the DONE cycle.
REQ-020 DONE: oDone=1 for one cycle, oRngSel=0; next state IDLE; oValid SHALL drop to 0 the cycle after DONE.
REQ-021 Outside RUN, oRngSel SHALL be 0; outside CLR, oRngClr SHALL be 0.
REQ-022 oOnes SHALL saturate never (max 2^BITWIDTH fits BITWIDTH+1 bits) and SHALL hold its final value in IDLE until next accepted iStart.
REQ-023 iStart while oBusy=1 SHALL be ignored; iSource changes after acceptance SHALL not affect the stream.
REQ-024 iStart asserted in the DONE cycle SHALL be ignored; iStart in the following IDLE cycle SHALL be accepted (back-to-back gap of one cycle).
REQ-025 iSource=0 SHALL yield all-zero stream; with iRand a permutation of 0..2^BITWIDTH-1 over the stream, oOnes SHALL equal iSource exactly.
REQ-026 Start to oDone SHALL be 2^BITWIDTH+2 cycles (1 CLR + 2^BITWIDTH RUN + DONE entry).

Reset
REQ-027 iRstN=0 SHALL immediately force state IDLE, srcReg=0, counter=0, oBit=0, oValid=0, oDone=0, oOnes=0, oBusy=0, oRngSel=0, oRngClr=0, independent of iClk.
REQ-028 Reset asserted mid-RUN SHALL abort the stream with no oDone pulse; after release the block SHALL accept a new iStart normally.

Verification
REQ-029 BITWIDTH=8, iRand from ideal 0..255 permutation, iSource=0 -> 256 oValid cycles, all oBit=0, oOnes=0, one oDone 258 cycles after iStart.
REQ-030 iSource=128 -> oOnes=128 at oDone; iSource=255 -> oOnes=255; never 256.
REQ-031 oRngClr high exactly one cycle before the first oRngSel cycle; oRngSel high exactly 256 consecutive cycles per stream.
REQ-032 iStart pulsed and iSource changed during RUN -> no restart, oOnes reflects originally latched value.
REQ-033 iRstN low for one cycle at RUN cycle 100 -> all outputs 0 asynchronously, no oDone; subsequent iStart with iSource=64 -> oOnes=64.
REQ-034 Back-to-back: iStart held high continuously -> streams separated by exactly one IDLE cycle, each oOnes correct.

Source files
------------

// File: rtl/sobol_bsgen.sv
// Stochastic bitstream generator: compares a latched operand against an upstream
// Sobol sequence for 2^BITWIDTH cycles and counts the emitted ones.
module sobol_bsgen #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic [BITWIDTH-1:0] iSource,
  input  logic [BITWIDTH-1:0] iRand,
  output logic                oRngSel,
  output logic                oRngClr,
  output logic                oBit,
  output logic                oValid,
  output logic                oBusy,
  output logic                oDone,
  output logic [BITWIDTH:0]   oOnes
);

  localparam int OW = BITWIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] src_q, src_d;
  logic [BITWIDTH-1:0] cnt_q, cnt_d;
  logic                bit_q, bit_d;
  logic                valid_q, valid_d;
  logic [OW-1:0]       ones_q, ones_d;
  logic                cmp;

  assign cmp = (src_q > iRand);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    bit_d   = 1'b0;
    valid_d = 1'b0;
    ones_d  = ones_q;
    oRngSel = 1'b0;
    oRngClr = 1'b0;
    oDone   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          src_d   = iSource;
          cnt_d   = '0;
          ones_d  = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        oRngClr = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Bit and count are registered together so oOnes tracks oBit exactly.
        oRngSel = 1'b1;
        bit_d   = cmp;
        valid_d = 1'b1;
        ones_d  = ones_q + OW'(cmp);
        cnt_d   = cnt_q + BITWIDTH'(1);
        if (cnt_q == {BITWIDTH{1'b1}}) state_d = S_DONE;
      end
      S_DONE: begin
        oDone   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oBit   = bit_q;
  assign oValid = valid_q;
  assign oOnes  = ones_q;
  assign oBusy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_sobol_bsgen.sv
// Directed/randomized bench for sobol_bsgen with an ideal shuffled-permutation RNG.
module tb_sobol_bsgen;

  localparam int BW  = 8;
  localparam int LEN = 1 << BW;

  logic          iClk, iRstN, iStart;
  logic [BW-1:0] iSource, iRand;
  logic          oRngSel, oRngClr, oBit, oValid, oBusy, oDone;
  logic [BW:0]   oOnes;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] perm [LEN];
  logic [BW-1:0] idx = '0;
  bit            exp_bits [LEN];
  int            exp_ones;

  sobol_bsgen #(.BITWIDTH(BW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iSource(iSource), .iRand(iRand),
    .oRngSel(oRngSel), .oRngClr(oRngClr), .oBit(oBit), .oValid(oValid),
    .oBusy(oBusy), .oDone(oDone), .oOnes(oOnes)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Ideal upstream generator: clear resets the index, select advances it.
  always @(posedge iClk) begin
    if (oRngClr) idx <= '0;
    else if (oRngSel) idx <= idx + 8'd1;
  end
  assign iRand = perm[idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // New random permutation plus the expected bitstream for operand src.
  task automatic prepare(input logic [BW-1:0] src);
    logic [BW-1:0] t;
    int j;
    for (int i = 0; i < LEN; i++) perm[i] = BW'(i);
    for (int i = LEN - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    exp_ones = 0;
    for (int k = 0; k < LEN; k++) begin
      exp_bits[k] = (int'(src) > int'(perm[k]));
      exp_ones += int'(exp_bits[k]);
    end
  endtask

  // Entered at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_stream(input logic [BW-1:0] src, input bit hold_start, input bit disturb);
    int  vidx = 0, sel_cnt = 0;
    bit  done_seen = 0;
    prepare(src);
    iSource = src;
    iStart  = 1'b1;
    @(negedge iClk);
    chk("clr_phase", {oBusy, oRngClr, oRngSel, oValid}, 4'b1100);
    if (!hold_start) iStart = 1'b0;
    for (int c = 2; c <= 300 && !done_seen; c++) begin
      @(negedge iClk);
      chk("rngclr_low", oRngClr, 0);
      chk("rngsel_window", oRngSel, (c >= 2 && c <= LEN + 1) ? 1 : 0);
      if (oRngSel) sel_cnt++;
      if (oValid) begin
        if (vidx < LEN) chk($sformatf("bit%0d", vidx), oBit, exp_bits[vidx]);
        vidx++;
      end
      if (disturb && c == 50) begin iStart = 1'b1; iSource = ~src; end
      if (disturb && c == 52) iStart = 1'b0;
      if (oDone) begin
        done_seen = 1;
        chk("done_latency", c, LEN + 2);
        chk("ones_final", oOnes, exp_ones);
        chk("ones_eq_src", oOnes, src);
        chk("valid_count", vidx, LEN);
        chk("sel_count", sel_cnt, LEN);
        chk("done_sel_low", oRngSel, 0);
      end
    end
    chk("done_seen", done_seen, 1);
    @(negedge iClk);
    chk("post_idle", {oBusy, oValid, oDone}, 3'b000);
    chk("ones_hold", oOnes, exp_ones);
  endtask

  initial begin
    iRstN = 1'b0; iStart = 1'b0; iSource = '0;
    for (int i = 0; i < LEN; i++) perm[i] = BW'(i);
    #1;
    chk("reset_outs", {oRngSel, oRngClr, oBit, oValid, oBusy, oDone, oOnes}, 0);
    @(negedge iClk); @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    chk("idle_after_reset", {oBusy, oRngSel, oRngClr}, 0);

    run_stream(8'd0,   0, 0);
    run_stream(8'd128, 0, 0);
    run_stream(8'd255, 0, 0);
    run_stream(BW'($urandom_range(254, 1)), 0, 0);
    run_stream(8'd77,  0, 1);

    // Idle hold with no start.
    repeat (3) @(negedge iClk);
    chk("idle_hold_busy", oBusy, 0);
    chk("idle_hold_ones", oOnes, exp_ones);

    // Reset mid-RUN at stream cycle 100: asynchronous clear, no oDone afterwards.
    prepare(8'd200);
    iSource = 8'd200; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (101) @(negedge iClk);
    chk("mid_run_busy", {oBusy, oRngSel}, 2'b11);
    #2 iRstN = 1'b0;
    #1;
    chk("async_reset_outs", {oRngSel, oRngClr, oBit, oValid, oBusy, oDone, oOnes}, 0);
    @(negedge iClk);
    iRstN = 1'b1;
    begin
      int dcnt = 0;
      for (int c = 0; c < 270; c++) begin
        @(negedge iClk);
        if (oDone || oBusy) dcnt++;
      end
      chk("no_done_after_abort", dcnt, 0);
    end
    run_stream(8'd64, 0, 0);

    // Back-to-back with iStart held high.
    run_stream(8'd33, 1, 0);
    chk("b2b_start_held", {oBusy, iStart}, 2'b01);
    run_stream(BW'($urandom_range(255, 0)), 1, 0);
    run_stream(8'd250, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
